// File: rtl/accumulator_ctrl.sv
// Tile sequencer for the skewed, column-banked accumulator. It counts row writes,
// waits out the per-bank commit skew, then streams rows out over valid/ready.
module accumulator_ctrl #(
    parameter int unsigned SYSTOLIC_SIZE  = 8,
    parameter int unsigned PATTERN_NUMBER = 1,
    parameter int unsigned DEPTH          = PATTERN_NUMBER * SYSTOLIC_SIZE,
    parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  test_mode_in,
    input  logic                  ps_valid,
    output logic                  acc_wr_en,
    output logic [ADDR_WIDTH-1:0] acc_wr_addr,
    output logic                  acc_test_mode,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ps_overflow
);

    localparam int unsigned DRAIN_W = $clog2(SYSTOLIC_SIZE) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(SYSTOLIC_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DRAIN,
        S_READ,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  mode_q, mode_d;
    logic                  ovf_q, ovf_d;

    // Next-state logic; abort overrides every other input in the same cycle.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        drain_d  = drain_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;

        if (abort) begin
            state_d  = S_IDLE;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            drain_d  = '0;
        end else begin
            if (ps_valid && (state_q == S_DRAIN || state_q == S_READ || state_q == S_DONE)) begin
                ovf_d = 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_WRITE;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        mode_d   = test_mode_in;
                        ovf_d    = 1'b0;
                    end
                end
                S_WRITE: begin
                    if (ps_valid) begin
                        if (wr_cnt_q == LAST_ADDR) begin
                            // Test mode bypasses the skew wait entirely.
                            state_d = mode_q ? S_READ : S_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end else begin
                            wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Bank i commits i cycles after bank 0.
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_d = S_READ;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                S_READ: begin
                    if (out_ready) begin
                        if (rd_cnt_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            drain_q  <= '0;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            drain_q  <= drain_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
        end
    end

    // Write strobe follows the array directly so a row lands in the cycle it is presented.
    assign acc_wr_en     = (state_q == S_WRITE) && ps_valid && !abort;
    assign acc_wr_addr   = wr_cnt_q;
    assign acc_rd_addr   = rd_cnt_q;
    assign acc_test_mode = mode_q;
    assign out_valid     = (state_q == S_READ);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign ps_overflow   = ovf_q;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Directed bench for accumulator_ctrl with S=8, P=1, DEPTH=8.
module tb_accumulator_ctrl;

    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          test_mode_in;
    logic          ps_valid;
    logic          acc_wr_en;
    logic [AW-1:0] acc_wr_addr;
    logic          acc_test_mode;
    logic [AW-1:0] acc_rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          ps_overflow;

    int errors = 0;
    int checks = 0;

    accumulator_ctrl #(
        .SYSTOLIC_SIZE (8),
        .PATTERN_NUMBER(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .test_mode_in (test_mode_in),
        .ps_valid     (ps_valid),
        .acc_wr_en    (acc_wr_en),
        .acc_wr_addr  (acc_wr_addr),
        .acc_test_mode(acc_test_mode),
        .acc_rd_addr  (acc_rd_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .ps_overflow  (ps_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full tile with out_ready high and gap-free writes; optional stray row in DRAIN.
    task automatic run_tile(input bit mode, input bit inj);
        start = 1'b1; test_mode_in = mode; ps_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("pre_start_busy", busy, 0);
        tick();
        start = 1'b0; test_mode_in = ~mode;
        for (int i = 0; i < 8; i++) begin
            ps_valid = 1'b1;
            #1;
            chk("wr_en", acc_wr_en, 1);
            chk("wr_addr", acc_wr_addr, i);
            chk("wr_busy", busy, 1);
            chk("wr_test_mode", acc_test_mode, mode);
            chk("wr_out_valid", out_valid, 0);
            if (i == 0) chk("ovf_cleared", ps_overflow, 0);
            tick();
        end
        ps_valid = 1'b0;
        if (!mode) begin
            for (int d = 0; d < 7; d++) begin
                ps_valid = inj && (d == 2);
                #1;
                chk("drain_wr_en", acc_wr_en, 0);
                chk("drain_out_valid", out_valid, 0);
                chk("drain_busy", busy, 1);
                if (inj && d == 3) chk("drain_ovf_set", ps_overflow, 1);
                tick();
            end
        end
        ps_valid = 1'b0;
        for (int r = 0; r < 8; r++) begin
            #1;
            chk("rd_valid", out_valid, 1);
            chk("rd_addr", acc_rd_addr, r);
            chk("rd_done", done, 0);
            tick();
        end
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_ovf", ps_overflow, inj);
        tick();
        #1;
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);
        chk("end_test_mode", acc_test_mode, mode);
        chk("end_ovf", ps_overflow, inj);
    endtask

    initial begin
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int exp_wr;
        int exp_rd;
        int hs;
        int cyc;
        bit pv;
        bit rdy;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; test_mode_in = 1'b0;
        ps_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_wr_en", acc_wr_en, 0);
        chk("rst_wr_addr", acc_wr_addr, 0);
        chk("rst_rd_addr", acc_rd_addr, 0);
        chk("rst_test_mode", acc_test_mode, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ps_overflow, 0);
        rst_n = 1'b1;
        tick();

        run_tile(1'b0, 1'b0);
        run_tile(1'b1, 1'b0);

        // Gapped writes with a stray start, then read under alternating backpressure.
        start = 1'b1; test_mode_in = 1'b0;
        tick();
        start = 1'b0;
        exp_wr = 0; cyc = 0;
        while (exp_wr < 8 && cyc < 40) begin
            pv = pat[cyc % 5];
            ps_valid = pv;
            start = (cyc == 1);
            #1;
            chk("gap_wr_en", acc_wr_en, pv);
            chk("gap_wr_addr", acc_wr_addr, exp_wr);
            chk("gap_busy", busy, 1);
            if (pv) exp_wr++;
            cyc++;
            tick();
        end
        start = 1'b0; ps_valid = 1'b0;
        for (int d = 0; d < 7; d++) begin
            #1;
            chk("gap_drain_valid", out_valid, 0);
            tick();
        end
        exp_rd = 0; hs = 0; rdy = 1'b1; cyc = 0;
        while (hs < 8 && cyc < 40) begin
            out_ready = rdy;
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_rd_addr", acc_rd_addr, exp_rd);
            chk("bp_done", done, 0);
            if (rdy) begin
                exp_rd++;
                hs++;
            end
            rdy = ~rdy;
            cyc++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_done_pulse", done, 1);
        tick();
        #1;
        chk("bp_end_busy", busy, 0);

        // Abort in READ at rd_addr=3.
        start = 1'b1; test_mode_in = 1'b0;
        tick();
        start = 1'b0; ps_valid = 1'b1;
        repeat (8) tick();
        ps_valid = 1'b0;
        repeat (7) tick();
        out_ready = 1'b1;
        repeat (3) tick();
        abort = 1'b1;
        #1;
        chk("abort_rd_addr", acc_rd_addr, 3);
        chk("abort_valid", out_valid, 1);
        tick();
        abort = 1'b0;
        #1;
        chk("post_abort_busy", busy, 0);
        chk("post_abort_done", done, 0);
        chk("post_abort_valid", out_valid, 0);
        chk("post_abort_rd", acc_rd_addr, 0);
        chk("post_abort_wr", acc_wr_addr, 0);
        tick();
        #1;
        chk("post_abort_no_done", done, 0);
        run_tile(1'b0, 1'b0);

        // Overflow set in DRAIN, held through done, cleared by next start.
        run_tile(1'b0, 1'b1);
        run_tile(1'b0, 1'b0);

        // Asynchronous reset mid-WRITE.
        start = 1'b1; test_mode_in = 1'b1;
        tick();
        start = 1'b0; ps_valid = 1'b1;
        repeat (5) tick();
        #1;
        chk("pre_rst_wr_addr", acc_wr_addr, 5);
        chk("pre_rst_test_mode", acc_test_mode, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", acc_wr_en, 0);
        chk("arst_wr_addr", acc_wr_addr, 0);
        chk("arst_test_mode", acc_test_mode, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_done", done, 0);
        ps_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("arst_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
